// File: rtl/enc_sched.sv
// enc_sched: round-robin scheduler sharing one byte-wide encryption engine
// between NUM_REQ requesters.
//
// The requester bytes are granted one per cycle and issued to the engine
// with their normalised direction and shift. A tag pipe follows each byte
// through the engine so that the result can be returned with its requester
// ID. The engine only advances on eng_en, so bubble enables are issued while
// any tagged byte is still in flight.
//
// Optional build macro:
//   ENC_SCHED_PRIO0_EN - requester 0 has strict priority over the others,
//                        which continue to share round-robin.
//
// Ports:
//   clock, rst          clock; asynchronous active-low reset
//   req_valid/ready     per-requester handshake (ready is combinational)
//   req_data            packed bytes, requester i at [8i+7:8i]
//   req_dir             packed 2-bit direction (11 is issued as 00)
//   req_shift           packed 5-bit raw shift (issued modulo 26)
//   flush_req           stop accepting and drain the engine
//   eng_en/din/direction/shift_num  registered engine inputs
//   eng_dout            engine result byte
//   rsp_valid/id/data   one-cycle tagged result
//   busy                FSM not idle
//   flush_done          one-cycle pulse when a drain completes
module enc_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned ENG_LAT = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ*2-1:0] req_dir,
  input  logic [NUM_REQ*5-1:0] req_shift,
  input  logic                 flush_req,
  output logic                 eng_en,
  output logic [7:0]           eng_din,
  output logic [1:0]           eng_direction,
  output logic [4:0]           eng_shift_num,
  input  logic [7:0]           eng_dout,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic                 flush_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_DRAIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_flush_done;
  logic              w_flush_done_nxt;

  logic [ID_W-1:0]   r_ptr;
  logic              w_found;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_hs;

  logic [7:0]        w_sel_data;
  logic [1:0]        w_sel_dir;
  logic [4:0]        w_sel_shift;
  logic [1:0]        w_dir_norm;
  logic [4:0]        w_shift_norm;

  logic              r_eng_en;
  logic [7:0]        r_eng_din;
  logic [1:0]        r_eng_dir;
  logic [4:0]        r_eng_shift;

  // Tag of the byte currently on eng_din.
  logic              r_din_v;
  logic [ID_W-1:0]   r_din_id;
  // Entry ENG_LAT-1 only supplies rsp_id; its valid bit is never consulted,
  // so valids are kept for entries 0..ENG_LAT-2 only.
  logic [ENG_LAT-2:0] r_tag_v;
  logic [ID_W-1:0]   r_tag_id [ENG_LAT];
  logic              r_rsp_valid;
  logic              w_any_tag;

  // Arbitration: first valid requester at or after the round-robin pointer.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req_valid[j] && (j == (32'(r_ptr) + k) % NUM_REQ)) begin
          w_found    = 1'b1;
          w_grant_id = ID_W'(j);
        end
      end
    end
`ifdef ENC_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      w_found    = 1'b1;
      w_grant_id = '0;
    end
`endif
    w_hs = w_found && !flush_req && (r_state != S_DRAIN);
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_hs && (32'(w_grant_id) == i);
    end
  end

  always_comb begin
    w_sel_data  = '0;
    w_sel_dir   = '0;
    w_sel_shift = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(w_grant_id) == i) begin
        w_sel_data  = req_data[i*8 +: 8];
        w_sel_dir   = req_dir[i*2 +: 2];
        w_sel_shift = req_shift[i*5 +: 5];
      end
    end
  end

  assign w_dir_norm   = (w_sel_dir == 2'b11) ? 2'b00 : w_sel_dir;
  assign w_shift_norm = (w_sel_shift >= 5'd26) ? (w_sel_shift - 5'd26) : w_sel_shift;

  // The outgoing eng_din byte is counted as in flight, the response slot is not.
  assign w_any_tag = r_din_v | (|r_tag_v);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_eng_en    <= 1'b0;
      r_eng_din   <= '0;
      r_eng_dir   <= '0;
      r_eng_shift <= '0;
      r_din_v     <= 1'b0;
      r_din_id    <= '0;
      r_tag_v     <= '0;
      for (int unsigned i = 0; i < ENG_LAT; i++) begin
        r_tag_id[i] <= '0;
      end
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_hs) begin
        r_ptr       <= (32'(w_grant_id) == NUM_REQ - 1) ? '0 : w_grant_id + 1'b1;
        r_eng_en    <= 1'b1;
        r_eng_din   <= w_sel_data;
        r_eng_dir   <= w_dir_norm;
        r_eng_shift <= w_shift_norm;
        r_din_v     <= 1'b1;
        r_din_id    <= w_grant_id;
      end else begin
        // Bubble while anything is in flight, otherwise let the engine idle.
        r_eng_en    <= w_any_tag;
        r_eng_din   <= '0;
        r_eng_dir   <= '0;
        r_eng_shift <= '0;
        r_din_v     <= 1'b0;
        r_din_id    <= '0;
      end

      if (r_eng_en) begin
        r_tag_v[0]  <= r_din_v;
        r_tag_id[0] <= r_din_id;
        for (int unsigned i = 1; i < ENG_LAT - 1; i++) begin
          r_tag_v[i] <= r_tag_v[i-1];
        end
        for (int unsigned i = 1; i < ENG_LAT; i++) begin
          r_tag_id[i] <= r_tag_id[i-1];
        end
        r_rsp_valid <= r_tag_v[ENG_LAT-2];
      end else begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_flush_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
          w_flush_done_nxt = 1'b1;
        end else if (|req_valid) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (flush_req) begin
          w_state_nxt = S_DRAIN;
        end else if (!w_any_tag && !(|req_valid)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!w_any_tag) begin
          w_flush_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_flush_done_nxt;
    end
  end

  assign eng_en        = r_eng_en;
  assign eng_din       = r_eng_din;
  assign eng_direction = r_eng_dir;
  assign eng_shift_num = r_eng_shift;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_tag_id[ENG_LAT-1];
  assign rsp_data      = eng_dout;
  assign busy          = (r_state != S_IDLE);
  assign flush_done    = r_flush_done;

endmodule

// File: tb/tb_enc_sched.sv
// Bench for enc_sched: directed stimulus with a response scoreboard.
// A stand-in engine (ENG_LAT-stage pipe advancing on eng_en, result
// d ^ {dir,0,shift}) supplies eng_dout.
module tb_enc_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned LAT = 4;

  logic              clock = 1'b0;
  logic              rst   = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*8-1:0]   req_data  = '0;
  logic [NR*2-1:0]   req_dir   = '0;
  logic [NR*5-1:0]   req_shift = '0;
  logic              flush_req = 1'b0;
  logic              eng_en;
  logic [7:0]        eng_din;
  logic [1:0]        eng_direction;
  logic [4:0]        eng_shift_num;
  logic [7:0]        eng_dout;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [7:0]        rsp_data;
  logic              busy;
  logic              flush_done;

  enc_sched #(.NUM_REQ(NR), .ID_W(IW), .ENG_LAT(LAT)) dut (
    .clock(clock), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_dir(req_dir), .req_shift(req_shift),
    .flush_req(flush_req),
    .eng_en(eng_en), .eng_din(eng_din), .eng_direction(eng_direction),
    .eng_shift_num(eng_shift_num), .eng_dout(eng_dout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .flush_done(flush_done)
  );

  always #5 clock = ~clock;

  logic [7:0] eng_pipe [LAT] = '{default: 8'h00};
  assign eng_dout = eng_pipe[LAT-1];
  always @(posedge clock) begin
    if (eng_en) begin
      eng_pipe[0] <= eng_din ^ {eng_direction, 1'b0, eng_shift_num};
      for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
    end
  end

  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0]    data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_rsp = 0;

  logic [7:0] d_tab  [4] = '{8'hA0, 8'h3C, 8'h96, 8'h5E};
  logic [1:0] dr_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [4:0] sh_tab [4] = '{5'd0, 5'd9, 5'd18, 5'd27};

  function automatic logic [7:0] model(input logic [7:0] d, input logic [1:0] dr,
                                       input logic [4:0] sh);
    logic [1:0] dn;
    logic [4:0] sn;
    dn = (dr == 2'b11) ? 2'b00 : dr;
    sn = (sh >= 5'd26) ? sh - 5'd26 : sh;
    return d ^ {dn, 1'b0, sn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int r, input logic [7:0] d, input logic [1:0] dr,
                         input logic [4:0] sh);
    req_data[r*8 +: 8]  = d;
    req_dir[r*2 +: 2]   = dr;
    req_shift[r*5 +: 5] = sh;
  endtask

  task automatic load_tabs();
    for (int r = 0; r < 4; r++) set_req(r, d_tab[r], dr_tab[r], sh_tab[r]);
  endtask

  task automatic push_exp(input int r);
    exp_t e;
    e.id   = IW'(r);
    e.data = model(req_data[r*8 +: 8], req_dir[r*2 +: 2], req_shift[r*5 +: 5]);
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req_valid = '0;
    flush_req = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      if (!busy && !eng_en) done = 1'b1;
    end
    chk({name, "_idle"}, 32'(done), 32'd1);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  always @(negedge clock) begin
    if (rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h, expected no response (t=%0t)",
                 rsp_id, rsp_data, $time);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rsp0;
    int pulses;
    int fd_cycle;
    bit done;
    bit seen;
    logic [3:0] seq [5];

    // Reset values
    repeat (2) tick();
    chk("rst_eng_en", 32'(eng_en), 0);
    chk("rst_eng_din", 32'(eng_din), 0);
    chk("rst_eng_dir", 32'(eng_direction), 0);
    chk("rst_eng_shift", 32'(eng_shift_num), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_flush_done", 32'(flush_done), 0);
    chk("rst_busy", 32'(busy), 0);

    // Single byte from requester 2
    reset_dut();
    set_req(2, 8'h41, 2'b10, 5'd3);
    req_valid = 4'b0100;
    push_exp(2);
    #1 chk("t1_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    chk("t1_c1_en", 32'(eng_en), 1);
    chk("t1_c1_din", 32'(eng_din), 32'h41);
    chk("t1_c1_shift", 32'(eng_shift_num), 3);
    chk("t1_c1_dir", 32'(eng_direction), 2);
    chk("t1_c1_busy", 32'(busy), 1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk("t1_bubble_en", 32'(eng_en), 1);
      chk("t1_bubble_din", 32'(eng_din), 0);
      chk("t1_bubble_rsp", 32'(rsp_valid), 0);
    end
    tick();
    chk("t1_c5_rsp_valid", 32'(rsp_valid), 1);
    tick();
    chk("t1_c6_en", 32'(eng_en), 0);
    chk("t1_c6_rsp", 32'(rsp_valid), 0);
    chk("t1_c6_busy", 32'(busy), 0);
    chk("t1_sb_empty", sb.size(), 0);

    // All four requesters continuously valid
    reset_dut();
    load_tabs();
    for (int k = 0; k < 8; k++) push_exp(k % 4);
    rsp0 = n_rsp;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_ready", 32'(req_ready), 32'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    wait_idle("t2", 30);
    chk("t2_rsp_count", n_rsp - rsp0, 8);

    // Direction and shift normalisation
    reset_dut();
    set_req(1, 8'h5A, 2'b01, 5'd28);
    req_valid = 4'b0010;
    push_exp(1);
    #1 chk("t3_ready_a", 32'(req_ready), 32'b0010);
    tick();
    set_req(3, 8'h10, 2'b11, 5'd31);
    req_valid = 4'b1000;
    push_exp(3);
    chk("t3_shift28", 32'(eng_shift_num), 2);
    chk("t3_dir01", 32'(eng_direction), 1);
    chk("t3_din_a", 32'(eng_din), 32'h5A);
    #1 chk("t3_ready_b", 32'(req_ready), 32'b1000);
    tick();
    set_req(0, 8'hE7, 2'b10, 5'd26);
    req_valid = 4'b0001;
    push_exp(0);
    chk("t3_shift31", 32'(eng_shift_num), 5);
    chk("t3_dir11", 32'(eng_direction), 0);
    chk("t3_din_b", 32'(eng_din), 32'h10);
    #1 chk("t3_ready_c", 32'(req_ready), 32'b0001);
    tick();
    set_req(1, 8'h22, 2'b01, 5'd25);
    req_valid = 4'b0010;
    push_exp(1);
    chk("t3_shift26", 32'(eng_shift_num), 0);
    chk("t3_dir10", 32'(eng_direction), 2);
    #1 chk("t3_ready_d", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    chk("t3_shift25", 32'(eng_shift_num), 25);
    chk("t3_dir01b", 32'(eng_direction), 1);
    wait_idle("t3", 30);

    // Flush with three bytes in flight and requests still pending
    reset_dut();
    load_tabs();
    for (int k = 0; k < 3; k++) push_exp(k);
    req_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_ready", 32'(req_ready), 32'(1 << k));
      tick();
    end
    flush_req = 1'b1;
    #1 chk("t4_ready_flush", 32'(req_ready), 0);
    pulses = 0;
    fd_cycle = -1;
    done = 1'b0;
    for (int c = 4; c < 30 && !done; c++) begin
      tick();
      if (flush_done) begin
        pulses++;
        fd_cycle = c;
      end
      chk("t4_ready_drain", 32'(req_ready), 0);
      if (!busy) done = 1'b1;
    end
    chk("t4_busy_fell", 32'(done), 1);
    chk("t4_flush_done_cycle", 32'(fd_cycle), 8);
    flush_req = 1'b0;
    req_valid = '0;
    repeat (3) begin
      tick();
      if (flush_done) pulses++;
    end
    chk("t4_flush_pulses", 32'(pulses), 1);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_sb_empty", sb.size(), 0);

    // Reset asserted with two bytes in flight
    reset_dut();
    load_tabs();
    req_valid = 4'b0011;
    #1 chk("t5_ready_a", 32'(req_ready), 32'b0001);
    tick();
    #1 chk("t5_ready_b", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_eng_en", 32'(eng_en), 0);
    chk("t5_eng_din", 32'(eng_din), 0);
    chk("t5_eng_dir", 32'(eng_direction), 0);
    chk("t5_eng_shift", 32'(eng_shift_num), 0);
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_rsp_id", 32'(rsp_id), 0);
    chk("t5_flush_done", 32'(flush_done), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (2) tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid || eng_en) seen = 1'b1;
    end
    chk("t5_quiet_after_reset", 32'(seen), 0);
    req_valid = 4'b1111;
    #1 chk("t5_ptr_reset", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // Requester 0 and 1 contending
    reset_dut();
    load_tabs();
`ifdef ENC_SCHED_PRIO0_EN
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    push_exp(0); push_exp(0); push_exp(0); push_exp(0); push_exp(1);
`else
    seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0010};
    push_exp(0); push_exp(1); push_exp(0); push_exp(1); push_exp(1);
`endif
    req_valid = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t6_ready", 32'(req_ready), 32'(seq[k]));
      tick();
    end
    req_valid = 4'b0010;
    #1 chk("t6_ready_last", 32'(req_ready), 32'(seq[4]));
    tick();
    req_valid = '0;
    wait_idle("t6", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enc_sched.md
Name: enc_sched

Overview:
- Round-robin scheduler that shares one byte-wide encryption engine (shift cipher, then permutation, then rolling XOR) between NUM_REQ requesters.
- Accepts per-requester bytes with their shift configuration, drives the engine's enable, data and config inputs, and tracks in-flight tags.
- Returns each result byte tagged with its requester ID.
- The engine pipeline advances only on enable, so the scheduler inserts bubble enables to drain results.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.
- ENG_LAT, 4, engine enables from a byte's issue to its result on eng_dout (minimum 2).

Ports:
- clock  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- req_data  in  NUM_REQ*8  packed bytes; requester i at [8i+7:8i].
- req_dir  in  NUM_REQ*2  packed direction: 00 none, 01 left, 10 right, 11 treated as 00.
- req_shift  in  NUM_REQ*5  packed raw shift amount, 0..31.
- flush_req  in  1  level; stop accepting and drain the engine.
- eng_en  out  1  engine enable; registered.
- eng_din  out  8  engine data; registered.
- eng_direction  out  2  engine direction; registered.
- eng_shift_num  out  5  engine shift, normalised to 0..25; registered.
- eng_dout  in  8  engine result byte.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  ID_W  requester ID of the current result.
- rsp_data  out  8  result byte; equals eng_dout while rsp_valid is high.
- busy  out  1  high when the FSM is not IDLE.
- flush_done  out  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset values:
  - eng_en=0, eng_din=0, eng_direction=0, eng_shift_num=0.
  - rsp_valid=0, rsp_id=0, flush_done=0, busy=0.
  - Round-robin pointer=0, all tag-pipe entries invalid, FSM in IDLE.
- Reset asserted mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them.
- FSM states:
  - IDLE: no tags valid. If flush_req=1, pulse flush_done the next cycle and stay in IDLE. Else if any req_valid, go to ACTIVE.
  - ACTIVE: grants allowed. If flush_req=1, go to DRAIN. Else if no tags valid and no req_valid, go to IDLE.
  - DRAIN: no grants and req_ready=0. When all tags are invalid, pulse flush_done and go to IDLE.
- Arbitration:
  - One grant per cycle in IDLE or ACTIVE, and only when flush_req=0.
  - Search starts at the round-robin pointer.
  - req_ready[g]=1 for the granted requester only; handshake is req_valid & req_ready.
  - After a handshake, the pointer moves to g+1 mod NUM_REQ. With no handshake, the pointer holds.
- Issue:
  - At the handshake edge, eng_din, eng_direction and eng_shift_num are loaded, and eng_en=1 in the following cycle.
  - eng_shift_num = req_shift mod 26 (26..31 map to 0..5). Direction 11 is issued as 00.
- Bubbles:
  - In a cycle with no handshake while any tag is valid, the next cycle carries eng_en=1, eng_din=0 and an invalid tag.
  - eng_en=0 only when no tag is valid and no handshake occurs.
- Tag pipe:
  - ENG_LAT entries of {valid, id}; it shifts only on edges where eng_en=1.
  - Entry 0 takes the tag of the byte currently on eng_din.
- Response:
  - At an edge with eng_en=1 and tag entry ENG_LAT-2 valid, rsp_valid goes high for one cycle.
  - rsp_id = last entry's id; rsp_data = eng_dout.
  - There is no backpressure on the response.
- Latency:
  - Isolated byte: rsp_valid arrives ENG_LAT+1 cycles after its handshake.
  - Back-to-back bytes: one result per cycle, in issue order.
- Simultaneous events: flush_req in the same cycle as req_valid means no grant. The engine's XOR counter also advances on bubbles; this is the defined sequence.

Optional Feature:
- Macro ENC_SCHED_PRIO0_EN.
- Defined: requester 0 has strict priority; when req_valid[0]=1 it wins every cycle, and the remaining requesters share round-robin.
- Undefined: pure round-robin across all requesters.

Test Plan:
- Single byte, requester 2: 8'h41, dir 10, shift 3, handshake at cycle 0 -> eng_din=8'h41 and eng_shift_num=3 in cycle 1; bubbles in cycles 2-4; rsp_valid with rsp_id=2 in cycle 5; eng_en=0 from cycle 6.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0; rsp_id follows the same order, one per cycle once the pipe is full.
- req_shift=28 with dir 01 -> eng_shift_num=2. dir 11 -> eng_direction=00.
- flush_req raised with 3 tags in flight and req_valid held -> req_ready stays 0; all 3 responses emerge; flush_done pulses once; busy falls.
- rst driven low 2 cycles after issuing 2 bytes -> all outputs return to reset values; no rsp_valid after reset release.
- With ENC_SCHED_PRIO0_EN, req_valid[0] and req_valid[1] held high -> requester 1 is never granted until req_valid[0] drops.
